// File: rtl/fetch_aligner_pkg.sv
// Shared types for the fetch aligner: execution-environment widths and the
// pending-halfword record carried between fetch words.
package fetch_aligner_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IALIGN = 16;

  typedef logic [XLEN-1:0] UIntX;
  typedef logic [31:0]     Inst;

  typedef struct packed {
    logic        valid;
    logic [15:0] bits;
    UIntX        pc;
  } FetchHalf;

  // A halfword starts a compressed instruction unless its two LSBs are 2'b11.
  function automatic logic half_is_rvc(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Splits/joins 32-bit fetch words into whole RVC or 32-bit instructions,
// one per decoder handshake, through a registered output stage.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter int unsigned IALIGN_P = IALIGN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  UIntX        flush_pc,
  input  logic        f_valid,
  output logic        f_ready,
  input  UIntX        f_addr,
  input  logic [31:0] f_bits,
  output logic        d_valid,
  input  logic        d_ready,
  output UIntX        d_pc,
  output Inst         d_bits,
  output logic        d_is_rvc
);

  localparam logic HALF = (IALIGN_P == 16);

  FetchHalf p, p_nxt;
  logic     skip, skip_nxt;
  logic     adv;
  logic     p_rvc, lo_rvc;
  UIntX     hi_pc;
  logic     emit;
  Inst      e_bits;
  UIntX     e_pc;
  logic     e_rvc;

  assign adv    = !d_valid || d_ready;
  assign p_rvc  = HALF && half_is_rvc(p.bits[1:0]);
  assign lo_rvc = HALF && half_is_rvc(f_bits[1:0]);
  assign hi_pc  = f_addr + UIntX'(2);

  always_comb begin
    f_ready  = 1'b0;
    emit     = 1'b0;
    e_bits   = '0;
    e_pc     = '0;
    e_rvc    = 1'b0;
    p_nxt    = p;
    skip_nxt = skip;
    if (flush) begin
      // Invalid P keeps the redirect target only as a record; it is never emitted.
      p_nxt    = '{valid: 1'b0, bits: 16'h0, pc: flush_pc};
      skip_nxt = HALF && flush_pc[1];
    end else if (adv) begin
      if (p.valid && p_rvc) begin
        emit        = 1'b1;
        e_bits      = {16'h0, p.bits};
        e_pc        = p.pc;
        e_rvc       = 1'b1;
        p_nxt.valid = 1'b0;
      end else begin
        f_ready = 1'b1;
        if (f_valid) begin
          if (p.valid) begin
            emit   = 1'b1;
            e_bits = {f_bits[15:0], p.bits};
            e_pc   = p.pc;
            p_nxt  = '{valid: 1'b1, bits: f_bits[31:16], pc: hi_pc};
          end else if (skip) begin
            p_nxt    = '{valid: 1'b1, bits: f_bits[31:16], pc: hi_pc};
            skip_nxt = 1'b0;
          end else if (lo_rvc) begin
            emit   = 1'b1;
            e_bits = {16'h0, f_bits[15:0]};
            e_pc   = f_addr;
            e_rvc  = 1'b1;
            p_nxt  = '{valid: 1'b1, bits: f_bits[31:16], pc: hi_pc};
          end else begin
            emit   = 1'b1;
            e_bits = f_bits;
            e_pc   = f_addr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid  <= 1'b0;
      d_pc     <= '0;
      d_bits   <= '0;
      d_is_rvc <= 1'b0;
      p        <= '0;
      skip     <= 1'b0;
    end else begin
      p    <= p_nxt;
      skip <= skip_nxt;
      if (flush) begin
        d_valid <= 1'b0;
      end else if (adv) begin
        d_valid <= emit;
        if (emit) begin
          d_pc     <= e_pc;
          d_bits   <= e_bits;
          d_is_rvc <= e_rvc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: table of fetch words with the
// instructions each one completes, scoreboarded against the decoder side.
module tb_fetch_aligner;
  import fetch_aligner_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  UIntX        flush_pc;
  logic        f_valid;
  logic        f_ready;
  UIntX        f_addr;
  logic [31:0] f_bits;
  logic        d_valid;
  logic        d_ready;
  UIntX        d_pc;
  Inst         d_bits;
  logic        d_is_rvc;

  fetch_aligner #(.IALIGN_P(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr), .f_bits(f_bits),
    .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_bits(d_bits),
    .d_is_rvc(d_is_rvc)
  );

  always #5 clk = ~clk;

  typedef struct {
    Inst  bits;
    UIntX pc;
    logic rvc;
  } exp_t;

  typedef struct {
    logic        redirect;
    UIntX        rpc;
    UIntX        addr;
    logic [31:0] word;
    int unsigned n;
    exp_t        e0;
    exp_t        e1;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input Inst b, input UIntX pc, input logic r);
    exp_t e;
    e.bits = b; e.pc = pc; e.rvc = r;
    return e;
  endfunction

  task automatic add_vec(input logic redir, input UIntX rpc, input UIntX addr,
                         input logic [31:0] word, input int unsigned n,
                         input exp_t e0, input exp_t e1);
    vec_t v;
    v.redirect = redir; v.rpc = rpc; v.addr = addr; v.word = word;
    v.n = n; v.e0 = e0; v.e1 = e1;
    vecs.push_back(v);
  endtask

  // Scoreboard and hold-stability monitor on the decoder side.
  logic hold_prev = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_valid", {31'b0, d_valid}, 32'h1);
        chk("hold_bits", d_bits, held.bits);
        chk("hold_pc", d_pc, held.pc);
        chk("hold_rvc", {31'b0, d_is_rvc}, {31'b0, held.rvc});
        chk("hold_f_ready", {31'b0, f_ready}, 32'h0);
      end
      if (d_valid && d_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out_pc", d_pc, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_bits", d_bits, e.bits);
          chk("out_pc", d_pc, e.pc);
          chk("out_rvc", {31'b0, d_is_rvc}, {31'b0, e.rvc});
        end
      end
      hold_prev = d_valid && !d_ready && !flush;
      held      = mk(d_bits, d_pc, d_is_rvc);
    end
  end

  // Upstream contract: accepted words are sequential from the redirect word.
  logic fresh = 1'b1;
  UIntX next_addr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        fresh     = 1'b0;
        next_addr = {flush_pc[XLEN-1:2], 2'b00};
      end else if (f_valid && f_ready) begin
        if (!fresh) chk("contract_addr", f_addr, next_addr);
        next_addr = f_addr + UIntX'(4);
        fresh     = 1'b0;
      end
    end
  end

  task automatic send(input UIntX addr, input logic [31:0] word);
    bit ok = 1'b0;
    f_valid = 1'b1; f_addr = addr; f_bits = word;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (f_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    f_valid = 1'b0;
  endtask

  task automatic do_flush(input UIntX pc);
    flush = 1'b1; flush_pc = pc;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0;
    f_valid = 1'b0; f_addr = '0; f_bits = '0; d_ready = 1'b1;

    add_vec(1, 32'h0,   32'h0,   32'h0000_0013, 1, mk(32'h0000_0013, 32'h0,   0), mk(0, 0, 0));
    add_vec(1, 32'h100, 32'h100, 32'h4501_4501, 2, mk(32'h0000_4501, 32'h100, 1), mk(32'h0000_4501, 32'h102, 1));
    add_vec(1, 32'h200, 32'h200, 32'h0013_4501, 1, mk(32'h0000_4501, 32'h200, 1), mk(0, 0, 0));
    add_vec(0, 32'h0,   32'h204, 32'hABCD_0000, 2, mk(32'h0000_0013, 32'h202, 0), mk(32'h0000_ABCD, 32'h206, 1));
    add_vec(1, 32'h400, 32'h400, 32'h1234_5673, 1, mk(32'h1234_5673, 32'h400, 0), mk(0, 0, 0));
    add_vec(1, 32'h500, 32'h500, 32'h1233_4501, 1, mk(32'h0000_4501, 32'h500, 1), mk(0, 0, 0));
    add_vec(0, 32'h0,   32'h504, 32'h5677_9AB7, 1, mk(32'h9AB7_1233, 32'h502, 0), mk(0, 0, 0));
    add_vec(0, 32'h0,   32'h508, 32'h0001_4321, 2, mk(32'h4321_5677, 32'h506, 0), mk(32'h0000_0001, 32'h50A, 1));
    add_vec(1, 32'h302, 32'h300, 32'h4501_0013, 1, mk(32'h0000_4501, 32'h302, 1), mk(0, 0, 0));
    add_vec(1, 32'h602, 32'h600, 32'h1B3B_7777, 0, mk(0, 0, 0), mk(0, 0, 0));
    add_vec(0, 32'h0,   32'h604, 32'h0001_2345, 2, mk(32'h2345_1B3B, 32'h602, 0), mk(32'h0000_0001, 32'h606, 1));
    add_vec(1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0001_0001, 2,
            mk(32'h0000_0001, 32'hFFFF_FFFC, 1), mk(32'h0000_0001, 32'hFFFF_FFFE, 1));

    repeat (2) @(negedge clk);
    chk("reset_d_valid", {31'b0, d_valid}, 32'h0);
    chk("reset_d_pc", d_pc, 32'h0);
    chk("reset_d_bits", d_bits, 32'h0);
    chk("reset_d_is_rvc", {31'b0, d_is_rvc}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].redirect && i != 0) begin
        drain();
        do_flush(vecs[i].rpc);
      end else if (vecs[i].redirect) begin
        do_flush(vecs[i].rpc);
      end
      if (vecs[i].n > 0) q.push_back(vecs[i].e0);
      if (vecs[i].n > 1) q.push_back(vecs[i].e1);
      send(vecs[i].addr, vecs[i].word);
    end
    drain();

    // Packed RVC pair: the second cycle serves P and refuses new words.
    do_flush(32'h700);
    q.push_back(mk(32'h0000_4501, 32'h700, 1));
    q.push_back(mk(32'h0000_4501, 32'h702, 1));
    send(32'h700, 32'h4501_4501);
    @(negedge clk);
    chk("rvc_pair_f_ready", {31'b0, f_ready}, 32'h0);
    @(posedge clk); #1;
    drain();

    // Straddling traffic with three cycles of decoder backpressure.
    do_flush(32'h200);
    q.push_back(mk(32'h0000_4501, 32'h200, 1));
    q.push_back(mk(32'h0000_0013, 32'h202, 0));
    q.push_back(mk(32'h0000_ABCD, 32'h206, 1));
    fork
      begin
        send(32'h200, 32'h0013_4501);
        send(32'h204, 32'hABCD_0000);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (d_valid) begin seen = 1'b1; break; end
        end
        if (!seen) chk("bp_first_valid_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        d_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d_ready = 1'b1;
      end
    join
    drain();

    // Flush while an instruction is held and P is valid.
    do_flush(32'h800);
    d_ready = 1'b0;
    send(32'h800, 32'h4501_4501);
    @(negedge clk);
    chk("pre_flush_d_valid", {31'b0, d_valid}, 32'h1);
    @(posedge clk); #1;
    do_flush(32'h900);
    @(negedge clk);
    chk("post_flush_d_valid", {31'b0, d_valid}, 32'h0);
    @(posedge clk); #1;
    q.push_back(mk(32'h0000_0013, 32'h900, 0));
    send(32'h900, 32'h0000_0013);
    d_ready = 1'b1;
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
